// File: rtl/fcp_pkg.sv
// ---------------------------------------------------------------------------
// fcp_pkg
// Shared definitions for the FCP single-wire transmit path: FSM state
// encoding, byte width, default timing values and the sync-length helper.
// ---------------------------------------------------------------------------
package fcp_pkg;

    localparam int FCP_BYTE_W       = 8;
    localparam int FCP_UI_CYCLE_DEF = 160;
    localparam int FCP_PING_UI_DEF  = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SYNC     = 3'd1,
        ST_BITS     = 3'd2,
        ST_PARITY   = 3'd3,
        ST_END_SYNC = 3'd4,
        ST_PING     = 3'd5
    } fcp_state_e;

    // A sync of SYNC_Q toggles starting from start_lvl ends at
    // start_lvl ^ sync_q_odd. If that equals the level that follows the
    // sync, one extra segment is needed so an edge marks the bit start.
    function automatic logic use_extra_seg(input logic start_lvl,
                                           input logic sync_q_odd,
                                           input logic target);
        return (start_lvl ^ sync_q_odd) == target;
    endfunction

endpackage

// File: rtl/fcp_crc8_ser.sv
// ---------------------------------------------------------------------------
// fcp_crc8_ser
// Bit-serial CRC-8, MSB first, no reflection, no final XOR.
// Ports:
//   clk    - system clock
//   rst    - synchronous reset, active high (register returns to CRC_INIT)
//   init   - reload CRC_INIT (has priority over en)
//   en     - shift one bit into the CRC
//   bit_in - bit to shift in
//   crc    - current CRC value
// ---------------------------------------------------------------------------
module fcp_crc8_ser
    import fcp_pkg::*;
#(
    parameter logic [FCP_BYTE_W-1:0] CRC_POLY = 8'h07,
    parameter logic [FCP_BYTE_W-1:0] CRC_INIT = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init,
    input  logic                  en,
    input  logic                  bit_in,
    output logic [FCP_BYTE_W-1:0] crc
);

    logic [FCP_BYTE_W-1:0] crc_q;
    logic [FCP_BYTE_W-1:0] crc_d;
    logic                  fb;

    always_comb begin
        fb    = crc_q[FCP_BYTE_W-1] ^ bit_in;
        crc_d = crc_q;
        if (init) begin
            crc_d = CRC_INIT;
        end else if (en) begin
            crc_d = {crc_q[FCP_BYTE_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/fcp_tx_ctrl_mb.sv
// ---------------------------------------------------------------------------
// fcp_tx_ctrl_mb
// FCP single-wire transmitter for 1..MAX_BYTES payload bytes. Each byte is
// preceded by a quarter-UI toggle sync, sent MSB first as NRZ plus odd parity;
// a CRC-8 byte follows the payload, and every frame closes with a ping.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   tx_start  - request pulse, accepted only while tx_ready=1
//   tx_type   - 0: ping only, 1: data frame
//   tx_len    - payload byte count for data frames
//   tx_data   - payload, byte k at [8k+7:8k], byte 0 sent first
//   tx_abort  - terminate the current transfer
//   tx_ready  - idle, can accept tx_start
//   tx_busy   - transfer in progress
//   tx_done   - one-cycle pulse on normal completion
//   tx_err    - one-cycle pulse for a data request with illegal tx_len
//   data      - line output
// ---------------------------------------------------------------------------
module fcp_tx_ctrl_mb
    import fcp_pkg::*;
#(
    parameter int          UI_CYCLE  = FCP_UI_CYCLE_DEF,
    parameter int          MAX_BYTES = 4,
    parameter int          PING_UI   = FCP_PING_UI_DEF,
    parameter int          SYNC_Q    = 2,
    parameter logic [7:0]  CRC_POLY  = 8'h07,
    parameter logic [7:0]  CRC_INIT  = 8'h00,
    localparam int         LEN_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             tx_start,
    input  logic                             tx_type,
    input  logic [LEN_W-1:0]                 tx_len,
    input  logic [FCP_BYTE_W*MAX_BYTES-1:0]  tx_data,
    input  logic                             tx_abort,
    output logic                             tx_ready,
    output logic                             tx_busy,
    output logic                             tx_done,
    output logic                             tx_err,
    output logic                             data
);

    localparam int   Q_CYC      = UI_CYCLE / 4;
    localparam int   PING_CYC   = PING_UI * UI_CYCLE;
    localparam int   CNT_W      = $clog2(PING_CYC + 1);
    localparam int   SEG_W      = $clog2(SYNC_Q + 2);
    localparam int   IDX_N      = 2 ** LEN_W;
    localparam logic SYNC_Q_ODD = 1'(SYNC_Q % 2);
    localparam logic [SEG_W-1:0] SEG_BASE = SEG_W'(SYNC_Q);
    localparam logic [SEG_W-1:0] SEG_MORE = SEG_W'(SYNC_Q + 1);

    fcp_state_e                        state_q;
    logic                              data_q;
    logic                              ready_q;
    logic                              done_q;
    logic                              err_q;
    logic [CNT_W-1:0]                  cyc_q;
    logic [SEG_W-1:0]                  seg_q;
    logic [SEG_W-1:0]                  sync_n_q;
    logic [2:0]                        bit_q;
    logic [LEN_W-1:0]                  byte_q;
    logic [LEN_W-1:0]                  len_q;
    logic [FCP_BYTE_W*MAX_BYTES-1:0]   tx_data_q;

    logic [FCP_BYTE_W-1:0] payload [IDX_N];
    logic [FCP_BYTE_W-1:0] cur_byte;
    logic [FCP_BYTE_W-1:0] nxt_byte;
    logic [FCP_BYTE_W-1:0] crc_val;
    logic [LEN_W-1:0]      nxt_idx;
    logic                  cur_bit;
    logic                  seg_end;
    logic                  ui_end;
    logic                  ping_end;
    logic                  len_ok;
    logic                  crc_init;
    logic                  crc_en;

    // Pad the payload view to a power of two so any byte index is in range.
    genvar gi;
    generate
        for (gi = 0; gi < IDX_N; gi++) begin : g_payload
            if (gi < MAX_BYTES) begin : g_real
                assign payload[gi] = tx_data_q[FCP_BYTE_W*gi +: FCP_BYTE_W];
            end else begin : g_pad
                assign payload[gi] = '0;
            end
        end
    endgenerate

    // Byte index len_q selects the CRC byte that trails the payload.
    assign nxt_idx  = byte_q + LEN_W'(1);
    assign cur_byte = (byte_q == len_q) ? crc_val : payload[byte_q];
    assign nxt_byte = (nxt_idx == len_q) ? crc_val : payload[nxt_idx];
    assign cur_bit  = cur_byte[3'd7 - bit_q];

    assign seg_end  = (cyc_q == CNT_W'(Q_CYC - 1));
    assign ui_end   = (cyc_q == CNT_W'(UI_CYCLE - 1));
    assign ping_end = (cyc_q == CNT_W'(PING_CYC - 1));
    assign len_ok   = (tx_len != '0) && (tx_len <= LEN_W'(MAX_BYTES));

    // CRC covers payload bits only; it is frozen while its own byte is sent.
    assign crc_init = tx_start && (state_q == ST_IDLE);
    assign crc_en   = (state_q == ST_BITS) && ui_end && (byte_q != len_q);

    fcp_crc8_ser #(
        .CRC_POLY (CRC_POLY),
        .CRC_INIT (CRC_INIT)
    ) u_crc (
        .clk    (clk),
        .rst    (rst),
        .init   (crc_init),
        .en     (crc_en),
        .bit_in (cur_bit),
        .crc    (crc_val)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            data_q    <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cyc_q     <= '0;
            seg_q     <= '0;
            sync_n_q  <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            len_q     <= '0;
            tx_data_q <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (tx_abort && (state_q != ST_IDLE)) begin
                state_q <= ST_IDLE;
                data_q  <= 1'b0;
                ready_q <= 1'b1;
                cyc_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (tx_start) begin
                            if (tx_type && !len_ok) begin
                                err_q <= 1'b1;
                            end else begin
                                ready_q   <= 1'b0;
                                cyc_q     <= '0;
                                len_q     <= tx_len;
                                tx_data_q <= tx_data;
                                if (!tx_type) begin
                                    state_q <= ST_PING;
                                    data_q  <= 1'b1;
                                end else begin
                                    state_q  <= ST_SYNC;
                                    data_q   <= ~data_q;
                                    seg_q    <= '0;
                                    byte_q   <= '0;
                                    sync_n_q <= use_extra_seg(data_q, SYNC_Q_ODD, tx_data[7])
                                                ? SEG_MORE : SEG_BASE;
                                end
                            end
                        end
                    end
                    ST_SYNC, ST_END_SYNC: begin
                        if (seg_end) begin
                            cyc_q <= '0;
                            if (seg_q == sync_n_q - SEG_W'(1)) begin
                                if (state_q == ST_SYNC) begin
                                    state_q <= ST_BITS;
                                    data_q  <= cur_byte[7];
                                    bit_q   <= '0;
                                end else begin
                                    state_q <= ST_PING;
                                    data_q  <= 1'b1;
                                end
                            end else begin
                                seg_q  <= seg_q + SEG_W'(1);
                                data_q <= ~data_q;
                            end
                        end else begin
                            cyc_q <= cyc_q + CNT_W'(1);
                        end
                    end
                    ST_BITS: begin
                        if (ui_end) begin
                            cyc_q <= '0;
                            if (bit_q == 3'd7) begin
                                state_q <= ST_PARITY;
                                data_q  <= ~^cur_byte;
                            end else begin
                                bit_q  <= bit_q + 3'd1;
                                data_q <= cur_byte[3'd6 - bit_q];
                            end
                        end else begin
                            cyc_q <= cyc_q + CNT_W'(1);
                        end
                    end
                    ST_PARITY: begin
                        if (ui_end) begin
                            cyc_q  <= '0;
                            seg_q  <= '0;
                            data_q <= ~data_q;
                            if (byte_q == len_q) begin
                                // CRC byte just finished: closing sync targets the ping high.
                                state_q  <= ST_END_SYNC;
                                sync_n_q <= use_extra_seg(data_q, SYNC_Q_ODD, 1'b1)
                                            ? SEG_MORE : SEG_BASE;
                            end else begin
                                state_q  <= ST_SYNC;
                                byte_q   <= nxt_idx;
                                sync_n_q <= use_extra_seg(data_q, SYNC_Q_ODD, nxt_byte[7])
                                            ? SEG_MORE : SEG_BASE;
                            end
                        end else begin
                            cyc_q <= cyc_q + CNT_W'(1);
                        end
                    end
                    ST_PING: begin
                        if (ping_end) begin
                            state_q <= ST_IDLE;
                            data_q  <= 1'b0;
                            done_q  <= 1'b1;
                            ready_q <= 1'b1;
                            cyc_q   <= '0;
                        end else begin
                            cyc_q <= cyc_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        data_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign tx_ready = ready_q;
    assign tx_busy  = ~ready_q;
    assign tx_done  = done_q;
    assign tx_err   = err_q;
    assign data     = data_q;

endmodule

// File: tb/tb_fcp_tx_ctrl_mb.sv
module tb_fcp_tx_ctrl_mb;

    localparam int UI   = 8;
    localparam int MAXB = 4;
    localparam int PUI  = 16;
    localparam int SQ   = 2;
    localparam int LW   = 3;
    localparam int QC   = UI / 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            tx_start;
    logic            tx_type;
    logic [LW-1:0]   tx_len;
    logic [8*MAXB-1:0] tx_data;
    logic            tx_abort;
    logic            tx_ready;
    logic            tx_busy;
    logic            tx_done;
    logic            tx_err;
    logic            data;

    fcp_tx_ctrl_mb #(
        .UI_CYCLE  (UI),
        .MAX_BYTES (MAXB),
        .PING_UI   (PUI),
        .SYNC_Q    (SQ),
        .CRC_POLY  (8'h07),
        .CRC_INIT  (8'h00)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_start (tx_start),
        .tx_type  (tx_type),
        .tx_len   (tx_len),
        .tx_data  (tx_data),
        .tx_abort (tx_abort),
        .tx_ready (tx_ready),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .tx_err   (tx_err),
        .data     (data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: expected line level per clock after the accept edge.
    bit         exp_q[$];
    bit         obs_q[$];
    logic [7:0] bytes_q[$];
    int         bits_start_q[$];
    int         sync_quarters;
    bit         model_lvl;

    int done_cnt;
    int done_idx;
    bit ready_at_done;
    bit busy_first;
    int extra_hi;

    function automatic logic [7:0] crc_ref(input int n);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < n; i++) begin
            c = c ^ bytes_q[i];
            for (int j = 0; j < 8; j++) begin
                if (c[7]) c = (c << 1) ^ 8'h07;
                else      c = c << 1;
            end
        end
        return c;
    endfunction

    task automatic push_level(input bit lvl, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(lvl);
    endtask

    // Toggle SQ quarter segments; add one more if the line would otherwise
    // already sit at the level that follows (no edge at the bit start).
    task automatic add_sync(input bit target);
        for (int s = 0; s < SQ; s++) begin
            model_lvl = ~model_lvl;
            push_level(model_lvl, QC);
            sync_quarters++;
        end
        if (model_lvl == target) begin
            model_lvl = ~model_lvl;
            push_level(model_lvl, QC);
            sync_quarters++;
        end
    endtask

    task automatic build_wave(input bit is_data);
        logic [7:0] bv;
        exp_q.delete();
        bits_start_q.delete();
        sync_quarters = 0;
        model_lvl = 1'b0;
        if (is_data) begin
            foreach (bytes_q[i]) begin
                bv = bytes_q[i];
                add_sync(bv[7]);
                bits_start_q.push_back(exp_q.size());
                for (int b = 7; b >= 0; b--) push_level(bv[b], UI);
                model_lvl = ~^bv;
                push_level(model_lvl, UI);
            end
            add_sync(1'b1);
        end
        push_level(1'b1, PUI * UI);
        exp_q.push_back(1'b0);
    endtask

    task automatic load_bytes(input int len, input logic [31:0] d);
        bytes_q.delete();
        for (int i = 0; i < len; i++) bytes_q.push_back(d[8*i +: 8]);
        bytes_q.push_back(crc_ref(len));
    endtask

    function automatic int first_mismatch();
        int n;
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (obs_q[i] != exp_q[i]) return i;
        if (obs_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    function automatic int lvl_at(input int which, input int idx);
        if (idx < 0) return -1;
        if (which == 0) return (idx < obs_q.size()) ? int'(obs_q[idx]) : -1;
        return (idx < exp_q.size()) ? int'(exp_q[idx]) : -1;
    endfunction

    // Issue one request and record the line until tx_done (bounded).
    task automatic run_frame(input bit typ, input int len, input logic [31:0] d,
                             input bit with_abort, input int poke_at);
        @(negedge clk);
        tx_type  = typ;
        tx_len   = LW'(len);
        tx_data  = d;
        tx_start = 1'b1;
        tx_abort = with_abort;
        @(posedge clk);
        obs_q.delete();
        done_cnt = 0;
        done_idx = -1;
        ready_at_done = 1'b0;
        extra_hi = 0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (k == 0) begin
                tx_start   = 1'b0;
                tx_abort   = 1'b0;
                busy_first = tx_busy;
            end
            if (k == poke_at) begin
                tx_start = 1'b1;
                tx_type  = 1'b1;
                tx_len   = 3'd1;
                tx_data  = $urandom;
            end else if (k == poke_at + 1) begin
                tx_start = 1'b0;
            end
            obs_q.push_back(data);
            if (tx_done) begin
                done_cnt++;
                done_idx = k;
                ready_at_done = tx_ready;
                break;
            end
        end
        tx_start = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (tx_done) done_cnt++;
            if (data) extra_hi++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tx_start = 1'b0; tx_type = 1'b0; tx_len = '0; tx_data = '0; tx_abort = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({data, tx_ready, tx_busy, tx_done, tx_err} !== 5'b01000) begin
            n_fail++;
            $display("FAIL reset_hold: got %b required 01000", {data, tx_ready, tx_busy, tx_done, tx_err});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({data, tx_ready, tx_busy, tx_done, tx_err} !== 5'b01000) begin
            n_fail++;
            $display("FAIL reset_release: got %b required 01000", {data, tx_ready, tx_busy, tx_done, tx_err});
        end
        $display("reset done");
    endtask

    task automatic test_ping();
        int m;
        build_wave(1'b0);
        run_frame(1'b0, 0, 32'h0, 1'b0, -1);
        m = first_mismatch();
        n_checks++;
        if (m != -1) begin
            n_fail++;
            $display("FAIL ping_wave: cycle %0d got %0d required %0d", m, lvl_at(0, m), lvl_at(1, m));
        end
        n_checks++;
        if (done_idx != PUI * UI) begin
            n_fail++;
            $display("FAIL ping_len: done at %0d required %0d", done_idx, PUI * UI);
        end
        n_checks++;
        if (done_cnt != 1 || !ready_at_done || !busy_first) begin
            n_fail++;
            $display("FAIL ping_hs: done_cnt %0d ready %0b busy %0b required 1 1 1", done_cnt, ready_at_done, busy_first);
        end
        $display("ping frame: %0d cycles", done_idx);
    endtask

    task automatic test_one_byte();
        int m;
        bytes_q.delete();
        bytes_q.push_back(8'hA5);
        bytes_q.push_back(8'h72);
        build_wave(1'b1);
        run_frame(1'b1, 1, 32'h0000_00A5, 1'b0, -1);
        m = first_mismatch();
        n_checks++;
        if (m != -1) begin
            n_fail++;
            $display("FAIL a5_wave: cycle %0d got %0d required %0d", m, lvl_at(0, m), lvl_at(1, m));
        end
        n_checks++;
        if (done_cnt != 1 || !ready_at_done) begin
            n_fail++;
            $display("FAIL a5_done: done_cnt %0d ready %0b required 1 1", done_cnt, ready_at_done);
        end
        $display("byte A5 frame: %0d cycles", done_idx);
    endtask

    task automatic test_four_bytes();
        int m;
        int total;
        load_bytes(4, 32'h0000_00FF);
        build_wave(1'b1);
        total = 9 * UI * 5 + sync_quarters * QC + PUI * UI;
        run_frame(1'b1, 4, 32'h0000_00FF, 1'b0, -1);
        m = first_mismatch();
        n_checks++;
        if (m != -1) begin
            n_fail++;
            $display("FAIL ff000000_wave: cycle %0d got %0d required %0d", m, lvl_at(0, m), lvl_at(1, m));
        end
        n_checks++;
        if (done_idx != total) begin
            n_fail++;
            $display("FAIL ff000000_len: done at %0d required %0d", done_idx, total);
        end
        $display("4-byte frame crc %02h: %0d cycles", bytes_q[4], done_idx);
    endtask

    task automatic test_random();
        int m;
        bit typ;
        int len;
        logic [31:0] d;
        for (int f = 0; f < 6; f++) begin
            typ = (f != 2);
            len = $urandom_range(1, 4);
            d   = $urandom;
            if (typ) load_bytes(len, d);
            build_wave(typ);
            run_frame(typ, len, d, (f == 3), -1);
            m = first_mismatch();
            n_checks++;
            if (m != -1) begin
                n_fail++;
                $display("FAIL rand_wave[%0d]: cycle %0d got %0d required %0d", f, m, lvl_at(0, m), lvl_at(1, m));
            end
            n_checks++;
            if (done_cnt != 1 || extra_hi != 0) begin
                n_fail++;
                $display("FAIL rand_done[%0d]: done_cnt %0d extra_hi %0d required 1 0", f, done_cnt, extra_hi);
            end
            $display("random frame %0d type %0d len %0d data %08h: %0d cycles", f, typ, len, d, done_idx);
        end
    endtask

    task automatic test_len_err();
        int bad_len [3] = '{0, 5, 7};
        foreach (bad_len[i]) begin
            @(negedge clk);
            tx_type  = 1'b1;
            tx_len   = LW'(bad_len[i]);
            tx_data  = $urandom;
            tx_start = 1'b1;
            @(negedge clk);
            tx_start = 1'b0;
            n_checks++;
            if ({tx_err, tx_ready, data} !== 3'b110) begin
                n_fail++;
                $display("FAIL len_err_pulse[%0d]: err/ready/data %b required 110", bad_len[i], {tx_err, tx_ready, data});
            end
            @(negedge clk);
            n_checks++;
            if ({tx_err, tx_ready, data} !== 3'b010) begin
                n_fail++;
                $display("FAIL len_err_after[%0d]: err/ready/data %b required 010", bad_len[i], {tx_err, tx_ready, data});
            end
            $display("len error request len %0d", bad_len[i]);
        end
    endtask

    task automatic test_abort();
        logic [31:0] d;
        int stop_at;
        int hits;
        int m;
        d = $urandom;
        load_bytes(2, d);
        build_wave(1'b1);
        stop_at = bits_start_q[1] + 10;
        @(negedge clk);
        tx_type = 1'b1; tx_len = 3'd2; tx_data = d; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (stop_at) @(negedge clk);
        n_checks++;
        if (data !== exp_q[stop_at] || tx_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_pre: data %b busy %b required %b 1", data, tx_busy, exp_q[stop_at]);
        end
        tx_abort = 1'b1;
        @(negedge clk);
        tx_abort = 1'b0;
        n_checks++;
        if ({data, tx_ready, tx_busy, tx_done} !== 4'b0100) begin
            n_fail++;
            $display("FAIL abort_now: data/ready/busy/done %b required 0100", {data, tx_ready, tx_busy, tx_done});
        end
        hits = 0;
        repeat (300) begin
            @(negedge clk);
            if (tx_done || data) hits++;
        end
        n_checks++;
        if (hits != 0) begin
            n_fail++;
            $display("FAIL abort_quiet: %0d active cycles required 0", hits);
        end
        $display("aborted frame data %08h at cycle %0d", d, stop_at);
        d = $urandom;
        load_bytes(3, d);
        build_wave(1'b1);
        run_frame(1'b1, 3, d, 1'b0, -1);
        m = first_mismatch();
        n_checks++;
        if (m != -1 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL abort_next_frame: mismatch at %0d done_cnt %0d required -1 1", m, done_cnt);
        end
        $display("post-abort frame data %08h: %0d cycles", d, done_idx);
    endtask

    task automatic test_back_to_back();
        int m;
        build_wave(1'b0);
        run_frame(1'b0, 0, 32'h0, 1'b0, 10);
        m = first_mismatch();
        n_checks++;
        if (m != -1) begin
            n_fail++;
            $display("FAIL busy_start_wave: cycle %0d got %0d required %0d", m, lvl_at(0, m), lvl_at(1, m));
        end
        n_checks++;
        if (done_cnt != 1 || extra_hi != 0) begin
            n_fail++;
            $display("FAIL busy_start_ignored: done_cnt %0d extra_hi %0d required 1 0", done_cnt, extra_hi);
        end
        $display("start during busy: ping %0d cycles", done_idx);
    endtask

    task automatic test_reset_in_ping();
        int hits;
        @(negedge clk);
        tx_type = 1'b0; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (20) @(negedge clk);
        n_checks++;
        if (data !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_ping_pre: data %b required 1", data);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({data, tx_ready, tx_busy, tx_done, tx_err} !== 5'b01000) begin
            n_fail++;
            $display("FAIL rst_ping: got %b required 01000", {data, tx_ready, tx_busy, tx_done, tx_err});
        end
        hits = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx_done || data) hits++;
        end
        n_checks++;
        if (hits != 0) begin
            n_fail++;
            $display("FAIL rst_ping_quiet: %0d active cycles required 0", hits);
        end
        $display("reset during ping");
    endtask

    initial begin
        test_reset();
        test_ping();
        test_one_byte();
        test_four_bytes();
        test_random();
        test_len_err();
        test_abort();
        test_back_to_back();
        test_reset_in_ping();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
